// File: rtl/axi_read_responder_pkg.sv
// Shared AXI read-channel types and constants for the read responder and its address generator.
// Also holds the AR legality check so that masters and the responder agree on what is an error.
package axi_read_responder_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

    // WRAP bursts must cover a power-of-two number of beats (2, 4, 8 or 16).
    function automatic logic ar_is_illegal(input logic [2:0] size,
                                           input axi_burst_t burst,
                                           input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != AXI_SIZE_8B) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi_read_responder_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts of 8-byte beats.
// Kept stand-alone so read masters can reuse the same address sequence.
module axi_burst_addr_gen
    import axi_read_responder_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [7:0]  len,
    input  axi_burst_t  burst,
    output logic [63:0] next_addr
);

    logic [63:0] incr_addr;
    logic [63:0] wrap_mask;

    assign incr_addr = addr + 64'd8;
    // (len+1)*8 - 1 is just len with three ones appended.
    assign wrap_mask = {53'd0, len, 3'b111};

    always_comb begin
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read responder over a word-addressed 64-bit memory with a backdoor preload port.
// Define AXI_RD_LATENCY_EN to insert LATENCY idle cycles between AR handshake and the first R beat.
module axi_read_responder
    import axi_read_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096
`ifdef AXI_RD_LATENCY_EN
    , parameter int LATENCY = 4
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_axi_arvalid,
    output logic        m_axi_arready,
    input  logic [63:0] m_axi_araddr,
    input  logic [7:0]  m_axi_arlen,
    input  logic [2:0]  m_axi_arsize,
    input  logic [1:0]  m_axi_arburst,
    output logic        m_axi_rvalid,
    input  logic        m_axi_rready,
    output logic [63:0] m_axi_rdata,
    output logic [1:0]  m_axi_rresp,
    output logic        m_axi_rlast,
    input  logic        bd_wr_en,
    input  logic [63:0] bd_wr_addr,
    input  logic [63:0] bd_wr_data
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [63:0] mem [MEM_WORDS];

    rd_state_t   state_reg, state_next;
    logic [63:0] addr_reg;
    logic [7:0]  len_reg;
    axi_burst_t  burst_reg;
    logic        err_reg;
    logic [7:0]  cnt_reg;
    logic [63:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic        rlast_reg;

    logic        latch;
    logic        load;
    logic        in_idle;
    axi_burst_t  ar_burst;
    logic        ar_err;
    logic [63:0] cur_addr;
    logic [7:0]  cur_len;
    axi_burst_t  cur_burst;
    logic        cur_err;
    logic [63:0] next_addr;
    logic [7:0]  beat_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] bd_idx;
    logic [63:0] rd_word;
    logic        unused_bd_addr;

    assign ar_burst = axi_burst_t'(m_axi_arburst);
    assign ar_err   = ar_is_illegal(m_axi_arsize, ar_burst, m_axi_arlen);
    assign in_idle  = (state_reg == ST_IDLE);

    // In IDLE the first beat is built straight from the AR channel; afterwards from the latched burst.
    assign cur_addr  = in_idle ? m_axi_araddr : addr_reg;
    assign cur_len   = in_idle ? m_axi_arlen  : len_reg;
    assign cur_burst = in_idle ? ar_burst     : burst_reg;
    assign cur_err   = in_idle ? ar_err       : err_reg;
    assign beat_idx  = (state_reg == ST_BURST) ? cnt_reg + 8'd1 : 8'd0;

    axi_burst_addr_gen u_addr_gen (
        .addr      (cur_addr),
        .len       (cur_len),
        .burst     (cur_burst),
        .next_addr (next_addr)
    );

    assign rd_idx = cur_addr[3 +: IDX_W];
    assign bd_idx = bd_wr_addr[3 +: IDX_W];
    assign unused_bd_addr = ^{bd_wr_addr[63:3+IDX_W], bd_wr_addr[2:0]};

    // A backdoor write landing on the edge that captures a beat is forwarded, so that beat sees it.
    assign rd_word = (bd_wr_en && (bd_idx == rd_idx)) ? bd_wr_data : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (bd_wr_en) begin
            mem[bd_idx] <= bd_wr_data;
        end
    end

`ifdef AXI_RD_LATENCY_EN
    localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              wait_done;

    assign wait_done = (wait_cnt_reg == WAIT_W'(LATENCY - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (latch) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        latch      = 1'b0;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (m_axi_arvalid) begin
                    latch = 1'b1;
`ifdef AXI_RD_LATENCY_EN
                    state_next = ST_WAIT;
`else
                    load       = 1'b1;
                    state_next = ST_BURST;
`endif
                end
            end
`ifdef AXI_RD_LATENCY_EN
            ST_WAIT: begin
                if (wait_done) begin
                    load       = 1'b1;
                    state_next = ST_BURST;
                end
            end
`endif
            ST_BURST: begin
                if (m_axi_rready) begin
                    if (rlast_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= '0;
            len_reg   <= '0;
            burst_reg <= BURST_FIXED;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            rresp_reg <= AXI_RESP_OKAY;
            rlast_reg <= 1'b0;
        end else begin
            if (latch) begin
                addr_reg  <= m_axi_araddr;
                len_reg   <= m_axi_arlen;
                burst_reg <= ar_burst;
                err_reg   <= ar_err;
            end
            if (load) begin
                addr_reg  <= next_addr;
                cnt_reg   <= beat_idx;
                rdata_reg <= cur_err ? 64'd0 : rd_word;
                rresp_reg <= cur_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                rlast_reg <= (beat_idx == cur_len);
            end else if ((state_reg == ST_BURST) && (state_next == ST_IDLE)) begin
                rlast_reg <= 1'b0;
            end
        end
    end

    assign m_axi_arready = in_idle && !reset;
    assign m_axi_rvalid  = (state_reg == ST_BURST);
    assign m_axi_rdata   = rdata_reg;
    assign m_axi_rresp   = rresp_reg;
    assign m_axi_rlast   = rlast_reg;

endmodule

// File: tb/tb_axi_read_responder.sv
// Randomised self-checking bench for axi_read_responder against a burst-level memory model.
// Honours AXI_RD_LATENCY_EN for the expected first-beat latency.
module tb_axi_read_responder;

    localparam int MEM_WORDS = 4096;
`ifdef AXI_RD_LATENCY_EN
    localparam int EXP_LAT = 5;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        bd_wr_en;
    logic [63:0] bd_wr_addr;
    logic [63:0] bd_wr_data;

    int checks = 0;
    int errors = 0;
    logic [63:0] ref_mem [MEM_WORDS];

    axi_read_responder #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk           (clk),
        .reset         (reset),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_araddr  (araddr),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_arburst (arburst),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rlast   (rlast),
        .bd_wr_en      (bd_wr_en),
        .bd_wr_addr    (bd_wr_addr),
        .bd_wr_data    (bd_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int word_of(input logic [63:0] a);
        return int'((a >> 3) % 64'(MEM_WORDS));
    endfunction

    // Address of beat i, computed directly rather than by stepping beat to beat.
    function automatic logic [63:0] beat_addr(input logic [63:0] start, input int len,
                                              input int burst, input int i);
        logic [63:0] bnd;
        logic [63:0] base;
        if (burst == 0) return start;
        if (burst == 2) begin
            bnd  = 64'((len + 1) * 8);
            base = start - (start % bnd);
            return base + ((start - base + 64'(8 * i)) % bnd);
        end
        return start + 64'(8 * i);
    endfunction

    function automatic bit is_err(input logic [2:0] size, input int burst, input int len);
        return (size != 3'b011) || (burst == 3) ||
               ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    task automatic bd_write(input int idx, input logic [63:0] data);
        @(negedge clk);
        bd_wr_en   = 1'b1;
        bd_wr_addr = 64'(idx) << 3;
        bd_wr_data = data;
        @(posedge clk);
        ref_mem[idx] = data;
        #1 bd_wr_en = 1'b0;
    endtask

    // mode 0: rready high, 1: toggles each cycle, 2: random. stall_beat >= 0 stalls that beat
    // for three cycles and backdoor-writes its word and the following one during the stall.
    task automatic run_burst(input logic [63:0] addr, input int len, input int burst,
                             input logic [2:0] size, input int mode, input int stall_beat,
                             input string name);
        int beat, cyc, stall_cnt, widx;
        bit err, seen;
        logic [63:0] snap;
        logic [1:0]  exp_resp;
        err = is_err(size, burst, len);
        exp_resp = err ? 2'b10 : 2'b00;
        @(negedge clk);
        cyc = 0;
        while (arready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL %s arready_wait got %b want 1", name, arready);
            return;
        end
        arvalid = 1'b1;
        araddr  = addr;
        arlen   = 8'(len);
        arsize  = size;
        arburst = 2'(burst);
        @(posedge clk);
        #1 arvalid = 1'b0;
        beat = 0; cyc = 0; seen = 0; stall_cnt = 0; widx = 0; snap = '0;
        while (beat <= len && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bd_wr_en = 1'b0;
            if (rvalid === 1'b1 && !seen) begin
                seen = 1;
                snap = err ? 64'd0 : ref_mem[word_of(beat_addr(addr, len, burst, beat))];
                if (beat == 0) begin
                    checks++;
                    if (cyc !== EXP_LAT) begin
                        errors++;
                        $display("FAIL %s first_rvalid_latency got %0d want %0d", name, cyc, EXP_LAT);
                    end
                end
            end
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 2 == 1);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (seen && beat == stall_beat && stall_cnt < 3) begin
                rready = 1'b0;
                if (stall_cnt < 2) begin
                    bd_wr_en   = 1'b1;
                    bd_wr_addr = beat_addr(addr, len, burst, beat + stall_cnt);
                    bd_wr_data = {$urandom, $urandom};
                    widx       = word_of(bd_wr_addr);
                end
                stall_cnt++;
            end
            if (rvalid === 1'b1) begin
                checks++;
                if (rdata !== snap) begin
                    errors++;
                    $display("FAIL %s beat%0d_data got %h want %h", name, beat, rdata, snap);
                end
                if (rready) begin
                    checks++;
                    if (rresp !== exp_resp) begin
                        errors++;
                        $display("FAIL %s beat%0d_resp got %b want %b", name, beat, rresp, exp_resp);
                    end
                    checks++;
                    if (rlast !== (beat == len)) begin
                        errors++;
                        $display("FAIL %s beat%0d_last got %b want %b", name, beat, rlast, beat == len);
                    end
                    beat++;
                    seen = 0;
                end
            end
            @(posedge clk);
            if (bd_wr_en) ref_mem[widx] = bd_wr_data;
        end
        #1 bd_wr_en = 1'b0;
        if (beat <= len) begin
            checks++;
            errors++;
            $display("FAIL %s burst_timeout got %0d beats want %0d", name, beat, len + 1);
        end
        rready = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s post_burst arready=%b rvalid=%b want 1 0", name, arready, rvalid);
        end
        $display("burst %s addr=%h len=%0d burst=%0d size=%0d beats=%0d", name, addr, len, burst, size, beat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({arready, rvalid, rlast, rresp, rdata} !== 69'd0) begin
            errors++;
            $display("FAIL reset_outputs got ar=%b rv=%b rl=%b rr=%b rd=%h want all 0",
                     arready, rvalid, rlast, rresp, rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_arready got %b want 1", arready);
        end
        $display("reset done");
    endtask

    task automatic preload_all();
        for (int i = 0; i < MEM_WORDS; i++) bd_write(i, {$urandom, $urandom});
        for (int i = 0; i < 8; i++) bd_write(i, 64'h100 + 64'(i));
    endtask

    task automatic test_incr();
        run_burst(64'h0, 7, 1, 3'b011, 0, -1, "incr");
    endtask

    task automatic test_stall_toggle();
        run_burst(64'h0, 7, 1, 3'b011, 1, -1, "toggle");
    endtask

    task automatic test_wrap();
        run_burst(64'h28, 3, 2, 3'b011, 0, -1, "wrap4");
        run_burst(64'h1038, 7, 2, 3'b011, 1, -1, "wrap8");
    endtask

    task automatic test_error();
        run_burst(64'h10, 1, 1, 3'b010, 0, -1, "err_size");
        run_burst(64'h0, 1, 1, 3'b011, 0, -1, "after_err");
        run_burst(64'h20, 2, 2, 3'b011, 0, -1, "err_wraplen");
        run_burst(64'h20, 1, 3, 3'b011, 0, -1, "err_rsvd");
    endtask

    task automatic test_backdoor();
        run_burst(64'h40, 3, 1, 3'b011, 0, 1, "bd_stall");
    endtask

    task automatic test_reset_mid();
        int beat;
        int cyc;
        logic [63:0] exp;
        @(negedge clk);
        arvalid = 1'b1; araddr = 64'h0; arlen = 8'd7; arsize = 3'b011; arburst = 2'b01;
        rready  = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        beat = 0; cyc = 0;
        while (beat < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (rvalid === 1'b1) begin
                exp = ref_mem[beat];
                checks++;
                if (rdata !== exp) begin
                    errors++;
                    $display("FAIL rstmid beat%0d_data got %h want %h", beat, rdata, exp);
                end
                beat++;
            end
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid beat2_valid got %b want 1", rvalid);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid in_reset rvalid=%b rlast=%b arready=%b want 0 0 0", rvalid, rlast, arready);
        end
        reset  = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid after_release arready=%b rvalid=%b want 1 0", arready, rvalid);
        end
        $display("burst rstmid abandoned after %0d beats", beat);
        run_burst(64'h8, 5, 1, 3'b011, 0, -1, "post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int burst, len;
            logic [2:0] size;
            logic [63:0] addr;
            burst = $urandom_range(0, 9) < 1 ? 3 : int'($urandom_range(0, 2));
            if (burst == 2) len = (2 << $urandom_range(0, 3)) - 1 + ($urandom_range(0, 7) == 0 ? 1 : 0);
            else len = $urandom_range(0, 20);
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b011;
            addr = {$urandom, $urandom} & ~64'h7;
            run_burst(addr, len, burst, size, 2, -1, "random");
        end
    endtask

    initial begin
        reset = 1'b1; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = 3'b011; arburst = 2'b01;
        rready = 1'b0; bd_wr_en = 1'b0; bd_wr_addr = '0; bd_wr_data = '0;
        test_reset();
        preload_all();
        test_incr();
        test_stall_toggle();
        test_wrap();
        test_error();
        test_backdoor();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
